// File: rtl/alu_operand_sequencer.sv
// Step-driven operand sequencer. A debounced push-button steps through loading A, B and an opcode,
// then shows a registered ALU result with a signed-overflow flag.
module alu_operand_sequencer #(
  parameter int NBITS = 3,
  parameter int NOPS  = 2
) (
  input  logic             clk_2,
  input  logic             rst_n,
  input  logic [NBITS-1:0] data_in,
  input  logic [NOPS-1:0]  op_in,
  input  logic             step,
  input  logic             clear,
  output logic [NBITS-1:0] a_q,
  output logic [NBITS-1:0] b_q,
  output logic [NOPS-1:0]  f_q,
  output logic [NBITS-1:0] result,
  output logic             ovf,
  output logic             valid,
  output logic [1:0]       state_o
);

  localparam int unsigned MSB = NBITS - 1;

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    SHOW    = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_step_s1;
  logic             r_step_s2;
  logic             r_step_d;
  logic             w_step_edge;
  logic [NBITS-1:0] r_a;
  logic [NBITS-1:0] r_b;
  logic [NOPS-1:0]  r_f;
  logic [NBITS-1:0] r_result;
  logic             r_ovf;
  logic             r_valid;
  logic [NBITS-1:0] w_alu_res;
  logic             w_alu_ovf;

  // Button synchroniser plus history flop; clear does not touch it, so an aborted edge is lost.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_step_d  <= 1'b0;
    end else begin
      r_step_s1 <= step;
      r_step_s2 <= r_step_s1;
      r_step_d  <= r_step_s2;
    end
  end

  assign w_step_edge = r_step_s2 & ~r_step_d;

  // ALU uses the live opcode so the result is ready on the LOAD_OP capture edge.
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (op_in)
      NOPS'(0): begin
        w_alu_res = r_a + r_b;
        w_alu_ovf = (r_a[MSB] == r_b[MSB]) && (w_alu_res[MSB] != r_a[MSB]);
      end
      NOPS'(1): begin
        w_alu_res = r_a - r_b;
        w_alu_ovf = (r_a[MSB] != r_b[MSB]) && (w_alu_res[MSB] != r_a[MSB]);
      end
      NOPS'(2): w_alu_res = r_a & r_b;
      NOPS'(3): w_alu_res = r_a | r_b;
      default:  w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = LOAD_A;
    end else if (w_step_edge) begin
      case (r_state)
        LOAD_A:  w_next_state = LOAD_B;
        LOAD_B:  w_next_state = LOAD_OP;
        LOAD_OP: w_next_state = SHOW;
        SHOW:    w_next_state = LOAD_A;
        default: w_next_state = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_f      <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
    end else if (clear) begin
      r_a      <= '0;
      r_b      <= '0;
      r_f      <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_step_edge) begin
        case (r_state)
          LOAD_A: r_a <= data_in;
          LOAD_B: r_b <= data_in;
          LOAD_OP: begin
            r_f      <= op_in;
            r_result <= w_alu_res;
            r_ovf    <= w_alu_ovf;
            r_valid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign a_q     = r_a;
  assign b_q     = r_b;
  assign f_q     = r_f;
  assign result  = r_result;
  assign ovf     = r_ovf;
  assign valid   = r_valid;
  assign state_o = r_state;

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
Parameters:
REQ-001 SHALL have parameter NBITS, default 3: operand and result width in bits (two's complement).
REQ-002 SHALL have parameter NOPS, default 2: opcode width in bits.

Ports:
REQ-003 SHALL have clk_2  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have data_in  input  NBITS  operand value from the switches.
REQ-006 SHALL have op_in  input  NOPS  opcode from the switches: 00 add, 01 sub, 10 and, 11 or.
REQ-007 SHALL have step  input  1  asynchronous push-button level; each rising edge advances the sequence.
REQ-008 SHALL have clear  input  1  synchronous abort back to LOAD_A.
REQ-009 SHALL have a_q  output  NBITS  captured operand A.
REQ-010 SHALL have b_q  output  NBITS  captured operand B.
REQ-011 SHALL have f_q  output  NOPS  captured opcode.
REQ-012 SHALL have result  output  NBITS  registered ALU result.
REQ-013 SHALL have ovf  output  1  registered signed-overflow flag.
REQ-014 SHALL have valid  output  1  one-cycle pulse marking a new result.
REQ-015 SHALL have state_o  output  2  current FSM state encoding.

Function
REQ-016 SHALL pass step through two synchroniser flops, step_s1 then step_s2, plus a history flop step_d.
REQ-017 SHALL define step_edge = step_s2 AND NOT step_d; a step first sampled high at edge k SHALL act at edge k+2.
REQ-018 SHALL produce exactly one step_edge per low-to-high transition of step, regardless of how long step is held high.
REQ-019 SHALL implement FSM states LOAD_A=00, LOAD_B=01, LOAD_OP=10 and SHOW=11, with state_o equal to the state register.
REQ-020 In LOAD_A, step_edge SHALL load a_q from data_in and move to LOAD_B.
REQ-021 In LOAD_B, step_edge SHALL load b_q from data_in and move to LOAD_OP.
REQ-022 In LOAD_OP, step_edge SHALL load f_q from op_in, load result and ovf computed from a_q, b_q and op_in, and move to SHOW.
REQ-023 valid SHALL be 1 for exactly the first cycle in SHOW and 0 in all other cycles.
REQ-024 In SHOW, step_edge SHALL move to LOAD_A; a_q, b_q, f_q, result and ovf SHALL hold until overwritten.
REQ-025 Without step_edge or clear, state and all registers SHALL hold.
REQ-026 Add SHALL be a+b mod 2^NBITS; ovf = (sign a == sign b) AND (sign result != sign a).
REQ-027 Sub SHALL be a-b mod 2^NBITS; ovf = (sign a != sign b) AND (sign result != sign a).
REQ-028 And and or SHALL be bitwise operations with ovf=0.
REQ-029 clear=1 at a clock edge SHALL force LOAD_A and zero a_q, b_q, f_q, result, ovf and valid, from any state.
REQ-030 When clear and step_edge coincide, clear SHALL win and that edge SHALL be discarded, not queued.
REQ-031 data_in and op_in SHALL be sampled only on the capturing edge; changes at other times SHALL have no effect.

Reset
REQ-032 rst_n=0 SHALL immediately force LOAD_A, zero all outputs, and zero step_s1, step_s2 and step_d.
REQ-033 A step held high through the release of rst_n SHALL produce exactly one step_edge (one capture) after release.
REQ-034 The first capture after release SHALL be possible no earlier than the third rising edge of clk_2.

Verification
REQ-035 a=011, b=001, op=00 via three steps -> result=100, ovf=1, valid pulses 1 cycle, state_o=11.
REQ-036 a=110, b=111, op=00 -> result=101, ovf=0; then a=100, b=001, op=01 -> result=011, ovf=1.
REQ-037 a=101, b=011, op=10 -> result=001, ovf=0; op=11 on the same operands -> result=111, ovf=0.
REQ-038 step held high for 50 cycles in LOAD_A -> only a_q loaded, state_o=01, b_q unchanged.
REQ-039 clear asserted in LOAD_OP coincident with step_edge -> state_o=00, all outputs 0, no valid pulse.
REQ-040 rst_n pulsed low mid-SHOW with result=100 -> all outputs 0 asynchronously, before the next clk_2 edge.
